// File: rtl/huffman_block_sequencer.sv
// huffman_block_sequencer: turns one zigzag coefficient block into a DC-diff / AC run-value / ZRL / EOB
// symbol stream, tracking a DC predictor per colour component.
module huffman_block_sequencer #(
    parameter int COEF_W = 8,
    parameter int NCOEF  = 64,
    parameter int NCOMP  = 3,
    parameter int CW     = (NCOMP > 1) ? $clog2(NCOMP) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [NCOEF*COEF_W-1:0]   blk_coefs,
    input  logic [CW-1:0]             blk_comp,
    input  logic                      pred_clear,
    output logic                      sym_valid,
    input  logic                      sym_ready,
    output logic                      sym_is_dc,
    output logic                      sym_zrl,
    output logic                      sym_eob,
    output logic [3:0]                sym_run,
    output logic [COEF_W:0]           sym_value,
    output logic [CW-1:0]             sym_comp,
    output logic                      sym_last,
    output logic                      blk_done
);
    localparam int KW = $clog2(NCOEF);

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t              state;
    logic [COEF_W-1:0]   coef [NCOEF];
    logic [COEF_W-1:0]   pred [NCOMP];
    logic [KW-1:0]       last_nz, nz_idx, k;
    logic [3:0]          run;
    logic [COEF_W-1:0]   coef0, pred_cur, coef_k;
    logic [COEF_W:0]     dc_diff;
    logic                eob_hit, nz;

    always_comb begin
        nz_idx = '0;
        for (int i = 1; i < NCOEF; i++)
            if (blk_coefs[i*COEF_W +: COEF_W] != '0) nz_idx = KW'(i);
    end

    // A restart marker in the capture cycle must already see a zero predictor.
    assign coef0     = blk_coefs[COEF_W-1:0];
    assign pred_cur  = pred_clear ? '0 : pred[blk_comp];
    assign dc_diff   = {coef0[COEF_W-1], coef0} - {pred_cur[COEF_W-1], pred_cur};
    assign coef_k    = coef[k];
    assign eob_hit   = k > last_nz;
    assign nz        = coef_k != '0;
    assign blk_ready = state == IDLE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_nz   <= '0;
            k         <= '0;
            run       <= '0;
            for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
            for (int i = 0; i < NCOMP; i++) pred[i] <= '0;
            sym_valid <= 1'b0;
            sym_is_dc <= 1'b0;
            sym_zrl   <= 1'b0;
            sym_eob   <= 1'b0;
            sym_run   <= '0;
            sym_value <= '0;
            sym_comp  <= '0;
            sym_last  <= 1'b0;
            blk_done  <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            if (pred_clear)
                for (int i = 0; i < NCOMP; i++) pred[i] <= '0;
            case (state)
                IDLE: if (blk_valid) begin
                    for (int i = 0; i < NCOEF; i++) coef[i] <= blk_coefs[i*COEF_W +: COEF_W];
                    pred[blk_comp] <= coef0;
                    last_nz   <= nz_idx;
                    k         <= KW'(1);
                    run       <= '0;
                    sym_valid <= 1'b1;
                    sym_is_dc <= 1'b1;
                    sym_zrl   <= 1'b0;
                    sym_eob   <= 1'b0;
                    sym_run   <= '0;
                    sym_value <= dc_diff;
                    sym_comp  <= blk_comp;
                    sym_last  <= 1'b0;
                    state     <= HOLD;
                end
                // EOB beats ZRL, so a ZRL is only ever followed by a nonzero coefficient.
                SCAN: if (eob_hit || nz || run == 4'd15) begin
                    sym_valid <= 1'b1;
                    sym_is_dc <= 1'b0;
                    sym_eob   <= eob_hit;
                    sym_zrl   <= !eob_hit && !nz;
                    sym_run   <= eob_hit ? '0 : run;
                    sym_value <= (eob_hit || !nz) ? '0 : {coef_k[COEF_W-1], coef_k};
                    sym_last  <= eob_hit || (nz && k == KW'(NCOEF - 1));
                    run       <= '0;
                    state     <= HOLD;
                end else begin
                    run <= run + 4'd1;
                    k   <= k + KW'(1);
                end
                HOLD: if (sym_ready) begin
                    sym_valid <= 1'b0;
                    blk_done  <= sym_last;
                    k         <= sym_is_dc ? k : k + KW'(1);
                    run       <= '0;
                    state     <= sym_last ? IDLE : SCAN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock)
        if (reset_n && blk_valid && blk_ready) assert (int'(blk_comp) < NCOMP);
endmodule

// File: tb/tb_huffman_block_sequencer.sv
// tb_huffman_block_sequencer: directed blocks with a symbol scoreboard, stall and mid-block reset.
module tb_huffman_block_sequencer;
    localparam int COEF_W = 8;
    localparam int NCOEF  = 64;
    localparam int NCOMP  = 3;
    localparam int CW     = 2;

    logic clock = 1'b0, reset_n = 1'b0, blk_valid = 1'b0, pred_clear = 1'b0, sym_ready = 1'b1;
    logic [NCOEF*COEF_W-1:0] blk_coefs = '0;
    logic [CW-1:0] blk_comp = '0;
    logic blk_ready, sym_valid, sym_is_dc, sym_zrl, sym_eob, sym_last, blk_done;
    logic [3:0] sym_run;
    logic [COEF_W:0] sym_value;
    logic [CW-1:0] sym_comp;

    logic [18:0] cur, held, exp_sym;
    logic [18:0] q[$];
    int pred_m[NCOMP];
    int c[NCOEF];
    int checks = 0, failures = 0, stall_mode = 0, stall_cnt = 0;
    bit stalled = 0, done_exp = 0;

    huffman_block_sequencer #(.COEF_W(COEF_W), .NCOEF(NCOEF), .NCOMP(NCOMP)) dut (
        .clock(clock), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_coefs(blk_coefs), .blk_comp(blk_comp), .pred_clear(pred_clear),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
        .sym_zrl(sym_zrl), .sym_eob(sym_eob), .sym_run(sym_run), .sym_value(sym_value),
        .sym_comp(sym_comp), .sym_last(sym_last), .blk_done(blk_done)
    );

    always #5 clock = ~clock;

    assign cur = {sym_is_dc, sym_zrl, sym_eob, sym_run, sym_value, sym_comp, sym_last};

    function automatic logic [18:0] mk(bit dc, bit zrl, bit eob, int run, int val, int comp, bit last);
        return {dc, zrl, eob, 4'(run), 9'(val), 2'(comp), last};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: list nonzero AC positions, split zero gaps into 16-zero ZRLs, EOB unless index 63 is nonzero.
    task automatic model(input int comp, input bit clr);
        int last = 0;
        int run = 0;
        if (clr) pred_m = '{default: 0};
        q.push_back(mk(1, 0, 0, 0, c[0] - pred_m[comp], comp, 0));
        pred_m[comp] = c[0];
        for (int i = 1; i < NCOEF; i++) if (c[i] != 0) last = i;
        for (int i = 1; i <= last; i++) begin
            if (c[i] == 0) run++;
            else begin
                while (run > 15) begin
                    q.push_back(mk(0, 1, 0, 15, 0, comp, 0));
                    run -= 16;
                end
                q.push_back(mk(0, 0, 0, run, c[i], comp, i == NCOEF - 1));
                run = 0;
            end
        end
        if (last != NCOEF - 1) q.push_back(mk(0, 0, 1, 0, 0, comp, 1));
    endtask

    task automatic send(input int comp, input bit clr);
        for (int i = 0; i < 200 && !blk_ready; i++) @(posedge clock) #1;
        check("blk_ready_wait", blk_ready, 1);
        for (int i = 0; i < NCOEF; i++) blk_coefs[i*COEF_W +: COEF_W] = 8'(c[i]);
        blk_comp   = 2'(comp);
        pred_clear = clr;
        blk_valid  = 1'b1;
        model(comp, clr);
        @(posedge clock) #1;
        blk_valid  = 1'b0;
        pred_clear = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && !(q.size() == 0 && blk_ready); i++) @(posedge clock) #1;
        check("drain", q.size(), 0);
    endtask

    // sym_ready: 0 = always ready, 1 = five stall cycles per symbol, 2 = stall on ZRL
    always @(posedge clock) begin
        #1;
        if (stall_mode == 2) sym_ready = !(sym_valid && sym_zrl);
        else if (stall_mode == 1 && sym_valid && stall_cnt < 5) begin
            sym_ready = 1'b0;
            stall_cnt++;
        end else begin
            sym_ready = 1'b1;
            stall_cnt = 0;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            stalled  = 0;
            done_exp = 0;
        end else begin
            if (done_exp || blk_done) begin
                check("blk_done", blk_done, done_exp);
                check("ready_after_done", blk_ready, 1);
            end
            done_exp = 0;
            if (stalled) check("stall_hold", {sym_valid, cur}, {1'b1, held});
            if (stall_mode == 1 && sym_valid) check("blk_ready_busy", blk_ready, 0);
            stalled = sym_valid && !sym_ready;
            held    = cur;
            if (sym_valid && sym_ready) begin
                exp_sym = q.size() != 0 ? q.pop_front() : 'x;
                check("sym", cur, exp_sym);
                done_exp = exp_sym[0] === 1'b1;
            end
        end
    end

    initial begin
        pred_m = '{default: 0};
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", sym_valid, 0);
        check("rst_sym", cur, 0);
        check("rst_ready", blk_ready, 1);
        check("rst_done", blk_done, 0);
        reset_n = 1'b1;
        @(posedge clock) #1;
        check("ready_after_rst", blk_ready, 1);

        c = '{default: 0}; c[0] = 5;
        send(0, 0); drain();
        c[0] = 3;
        send(0, 0); drain();
        send(1, 0); drain();

        c = '{default: 0}; c[20] = 7;
        send(0, 0); drain();

        c = '{default: 0}; c[0] = 1; c[63] = -1;
        send(2, 0); drain();

        stall_mode = 1;
        c = '{default: 0}; c[0] = -4; c[20] = 7;
        send(1, 0); drain();
        stall_mode = 0;

        c = '{default: 0}; c[0] = 4;
        send(0, 0); drain();
        c[0] = 9;
        send(0, 1); drain();

        stall_mode = 2;
        c[0] = 6; c[20] = 7;
        send(0, 0);
        for (int i = 0; i < 100 && !(sym_valid && sym_zrl); i++) @(posedge clock) #1;
        check("zrl_reached", {sym_valid, sym_zrl}, 2'b11);
        #2 reset_n = 1'b0;
        #1 check("rst_async_valid", sym_valid, 0);
        q.delete();
        pred_m = '{default: 0};
        stall_mode = 0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;

        c = '{default: 0}; c[0] = 2;
        send(0, 0); drain();

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/huffman_block_sequencer.md
Name: huffman_block_sequencer

Overview:
Parametrised successor to the JPEG Huffman encode controller. It accepts one zigzag-ordered coefficient block per handshake and computes the DC difference against a per-component predictor. It then run-length scans the AC coefficients and emits a symbol stream (DC diff, AC run/value, ZRL, EOB) over a valid/ready interface to the downstream Huffman table/bit-packer. It sits between the zigzag stage and the code-table lookup.

Parameters:
COEF_W, 8, signed coefficient width in bits
NCOEF, 64, coefficients per block (index 0 = DC); legal range 2..64
NCOMP, 3, number of colour components, each with its own DC predictor
CW, $clog2(NCOMP) (min 1), component-id width (derived)

Ports:
clock  in  1  clock
reset_n  in  1  reset
blk_valid  in  1  input block available
blk_ready  out  1  sequencer can accept a block
blk_coefs  in  NCOEF*COEF_W  signed coefficients; coef[k] = bits [k*COEF_W +: COEF_W]
blk_comp  in  CW  component id of the block (< NCOMP)
pred_clear  in  1  synchronous pulse: zero all DC predictors (restart marker)
sym_valid  out  1  symbol output valid
sym_ready  in  1  downstream accepts symbol
sym_is_dc  out  1  symbol is the DC difference
sym_zrl  out  1  symbol is ZRL (16 zeros)
sym_eob  out  1  symbol is EOB
sym_run  out  4  zero run preceding the value (AC only, else 0)
sym_value  out  COEF_W+1  signed value, sign-extended (DC diff or AC coef; 0 for ZRL/EOB)
sym_comp  out  CW  component id of the current block
sym_last  out  1  final symbol of the block
blk_done  out  1  one-cycle pulse when the last symbol handshakes

Behaviour:
- Reset: reset_n is asynchronous, active-low, on clock. State=IDLE, all predictors=0, and all sym_* outputs plus blk_done = 0. blk_ready = (state==IDLE), so it is 1 right after reset.
- States: IDLE, HOLD, SCAN.
- IDLE: on blk_valid & blk_ready:
  - Capture the coefficients and comp.
  - Compute last_nz = highest AC index k≥1 with coef[k]≠0 (0 if none).
  - Load the DC symbol: sym_value = coef[0] − pred[comp] at COEF_W+1 bits; is_dc=1, run=0.
  - Set pred[comp] <= coef[0], sym_valid=1, k=1, run=0. Go to HOLD. The DC symbol is valid the cycle after acceptance.
- pred_clear: takes effect before the subtraction in the same cycle. Capture coincident with pred_clear yields diff=coef[0] and pred[comp]=coef[0]. pred_clear in other states only zeros the predictors.
- SCAN: examine coef[k] each cycle, in the following priority order:
  - k>last_nz: load EOB (eob=1, value=0, run=0, last=1) and go to HOLD.
  - coef[k]≠0: load run, value=sext(coef[k]), last=(k==NCOEF−1), and go to HOLD.
  - coef[k]==0 & run==15: load ZRL (zrl=1, run=15, value=0), set run=0, and go to HOLD. This cannot occur beyond last_nz because EOB wins.
  - Otherwise: run++, k++, stay in SCAN.
- EOB suppression: no EOB is emitted when last_nz==NCOEF−1; the symbol at that index carries last=1.
- HOLD:
  - While sym_valid & !sym_ready, all sym_* outputs are held stable.
  - On handshake with last=1: pulse blk_done, sym_valid=0, go to IDLE (blk_ready=1 on the next cycle).
  - On any other handshake: sym_valid=0, k = k+1 (k stays 1 after DC), run=0 (except after ZRL, where run already=0), go to SCAN.
- Throughput: one zero coefficient per cycle in SCAN. Each symbol costs a SCAN cycle plus at least one HOLD cycle.
- Unused flags in any symbol are 0. sym_comp is constant for the whole block.
- Reset mid-block: the block is abandoned, predictors are zeroed, and sym_valid drops asynchronously.
- blk_comp ≥ NCOMP: undefined; the checker flags it.

Test Plan:
1. After reset, comp0, coef0=5, all AC=0, sym_ready=1 → DC(value=+5) then EOB(last=1); blk_done one cycle after the EOB handshake; blk_ready back high.
2. Next comp0 block with coef0=3 → DC value=−2 (0x1FE at COEF_W=8). Then a comp1 block with coef0=3 → DC value=+3 (separate predictor).
3. Only coef[20]=7 nonzero → DC, ZRL(run=15), AC(run=3, value=7), EOB(last=1).
4. Only coef[63]=−1 nonzero → DC, 3×ZRL, AC(run=14, value=0x1FF, last=1); no EOB emitted.
5. Hold sym_ready low for 5 cycles on each symbol of scenario 3 → sym_* stable across each stall; symbol order unchanged; blk_ready low until done.
6. pred_clear coincident with capture (coef0=9, pred was 4) → diff=+9. Then assert reset_n low during ZRL HOLD → sym_valid=0 immediately; next block comp0 coef0=2 → diff=+2.
